wbu: RTL and testbench

Write-back stage of the multi-cycle NPC core, directly downstream of the load/store stage. It accepts one retired instruction per valid/ready handshake and selects the GPR write-back value. It also owns the machine CSR set (mstatus, mtvec, mepc, mcause, minstret), computes the next PC, and hands that PC to the fetch stage through a second valid/ready handshake.

---
 rtl/wbu.sv | 245 ++++++++++++++++++++++++
 tb/tb_wbu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// wbu: write-back stage of the multi-cycle NPC core.
// Accepts one retired instruction per LSU handshake, drives the GPR write
// port for one cycle (WB), owns the machine CSRs, and hands the next PC to
// fetch through a valid/ready handshake (COMMIT).
// Ports:
//   clk, rst                 clock, async active-low reset
//   valid_in_lsu/ready_out_lsu  handshake from load/store stage
//   ben..rdata               retired-instruction fields
//   gpr_we/gpr_waddr/gpr_wdata  GPR write port
//   csr_raddr/csr_rdata      combinational CSR read port for decode
//   valid_out_ifu/ready_in_ifu/next_pc  handshake to fetch
//   commit                   one-cycle retire pulse (high during WB)
module wbu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_lsu,
    output logic        ready_out_lsu,
    input  logic        ben,
    input  logic [31:0] pc,
    input  logic [31:0] csr_out,
    input  logic [6:0]  opcode,
    input  logic        gpr_wen,
    input  logic [4:0]  rd,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [31:0] alu_out,
    input  logic [31:0] rdata,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        valid_out_ifu,
    input  logic        ready_in_ifu,
    output logic [31:0] next_pc,
    output logic        commit
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_d;
    logic   ready_d, valid_d, gpr_we_d, commit_d;
    logic   capture, wb_cycle;

    // Buffered instruction fields needed after the capture edge
    logic            b_ben;
    logic [XLEN-1:0] b_pc;
    logic [6:0]      b_opcode;
    logic [XLEN-1:0] b_alu_out;
    logic            b_csr_wen;
    logic [11:0]     b_csr_waddr;
    logic [XLEN-1:0] b_csr_wdata;
    logic            b_ecall;
    logic            b_mret;

    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
    logic [63:0]     minstret;

    logic [XLEN-1:0] wb_data_c;
    logic [XLEN-1:0] npc_c;
    logic [XLEN-1:0] b_pc_plus4;

    // Next-state and next-output decode; flags are registered below
    always_comb begin
        state_d  = state;
        ready_d  = 1'b0;
        valid_d  = 1'b0;
        gpr_we_d = 1'b0;
        commit_d = 1'b0;
        capture  = 1'b0;
        wb_cycle = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in_lsu) begin
                    capture  = 1'b1;
                    state_d  = WB;
                    gpr_we_d = gpr_wen && (rd != 5'd0);
                    commit_d = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            WB: begin
                wb_cycle = 1'b1;
                state_d  = COMMIT;
                valid_d  = 1'b1;
            end
            COMMIT: begin
                if (ready_in_ifu) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and handshake/strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ready_out_lsu <= 1'b1;
            valid_out_ifu <= 1'b0;
            gpr_we        <= 1'b0;
            commit        <= 1'b0;
        end else begin
            state         <= state_d;
            ready_out_lsu <= ready_d;
            valid_out_ifu <= valid_d;
            gpr_we        <= gpr_we_d;
            commit        <= commit_d;
        end
    end

    // Write-back value selected from the incoming fields at capture time
    always_comb begin
        wb_data_c = alu_out;
        case (opcode)
            OP_LOAD:         wb_data_c = rdata;
            OP_JAL, OP_JALR: wb_data_c = pc + XLEN'(4);
            OP_SYSTEM:       wb_data_c = csr_out;
            default:         wb_data_c = alu_out;
        endcase
    end

    // Instruction buffers and GPR write payload, held through WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_ben       <= 1'b0;
            b_pc        <= '0;
            b_opcode    <= '0;
            b_alu_out   <= '0;
            b_csr_wen   <= 1'b0;
            b_csr_waddr <= '0;
            b_csr_wdata <= '0;
            b_ecall     <= 1'b0;
            b_mret      <= 1'b0;
            gpr_waddr   <= '0;
            gpr_wdata   <= '0;
        end else if (capture) begin
            b_ben       <= ben;
            b_pc        <= pc;
            b_opcode    <= opcode;
            b_alu_out   <= alu_out;
            b_csr_wen   <= csr_wen;
            b_csr_waddr <= csr_waddr;
            b_csr_wdata <= csr_wdata;
            b_ecall     <= is_ecall;
            b_mret      <= is_mret;
            gpr_waddr   <= rd;
            gpr_wdata   <= wb_data_c;
        end
    end

    assign b_pc_plus4 = b_pc + XLEN'(4);

    // Next-PC priority: trap, trap return, taken jump/branch, fall-through
    always_comb begin
        npc_c = b_pc_plus4;
        if (b_ecall) begin
            npc_c = mtvec;
        end else if (b_mret) begin
            npc_c = mepc;
        end else if (b_ben && (b_opcode == OP_JALR)) begin
            npc_c = {b_alu_out[XLEN-1:1], 1'b0};
        end else if (b_ben) begin
            npc_c = b_alu_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_pc <= RESET_PC;
        end else if (wb_cycle) begin
            next_pc <= npc_c;
        end
    end

    // Machine CSRs; ecall overrides any explicit CSR write on the same instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus  <= 32'h0000_1800;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            minstret <= '0;
        end else if (wb_cycle) begin
            minstret <= minstret + 64'd1;
            if (b_ecall) begin
                mepc   <= b_pc;
                mcause <= 32'd11;
            end else if (b_csr_wen) begin
                case (b_csr_waddr)
                    CSR_MSTATUS: mstatus <= b_csr_wdata;
                    CSR_MTVEC:   mtvec   <= b_csr_wdata;
                    CSR_MEPC:    mepc    <= b_csr_wdata;
                    CSR_MCAUSE:  mcause  <= b_csr_wdata;
                    default:     ;
                endcase
            end
        end
    end

    // Combinational CSR read port
    always_comb begin
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus;
            CSR_MTVEC:     csr_rdata = mtvec;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MINSTRET:  csr_rdata = minstret[31:0];
            CSR_MINSTRETH: csr_rdata = minstret[63:32];
            default:       csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: self-checking bench for wbu. Directed vector table, randomized
// instructions against a behavioural model, and a reset-during-WB sequence.
module tb_wbu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk, rst;
    logic        valid_in_lsu, ready_out_lsu;
    logic        ben;
    logic [31:0] pc, csr_out;
    logic [6:0]  opcode;
    logic        gpr_wen;
    logic [4:0]  rd;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        is_ecall, is_mret;
    logic [31:0] alu_out, rdata;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        valid_out_ifu, ready_in_ifu;
    logic [31:0] next_pc;
    logic        commit;

    wbu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .valid_in_lsu(valid_in_lsu), .ready_out_lsu(ready_out_lsu),
        .ben(ben), .pc(pc), .csr_out(csr_out), .opcode(opcode),
        .gpr_wen(gpr_wen), .rd(rd), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .is_ecall(is_ecall), .is_mret(is_mret),
        .alu_out(alu_out), .rdata(rdata),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .valid_out_ifu(valid_out_ifu), .ready_in_ifu(ready_in_ifu),
        .next_pc(next_pc), .commit(commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ben;
        logic [31:0] pc;
        logic [31:0] csr_out;
        logic [6:0]  opcode;
        logic        gpr_wen;
        logic [4:0]  rd;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        is_ecall;
        logic        is_mret;
        logic [31:0] alu_out;
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          stall;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] npc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Architectural model of the CSR file
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    longint unsigned m_minstret;

    task automatic model_reset();
        m_mstatus  = 32'h0000_1800;
        m_mtvec    = 0;
        m_mepc     = 0;
        m_mcause   = 0;
        m_minstret = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // Expected GPR write and next PC for one instruction from the current model state
    task automatic model_predict(input instr_t i, output logic we, output logic [31:0] wd,
                                 output logic [31:0] npc);
        we = i.gpr_wen && (i.rd != 0);
        if (i.opcode == 7'b0000011)                             wd = i.rdata;
        else if (i.opcode == 7'b1101111 || i.opcode == 7'b1100111) wd = i.pc + 4;
        else if (i.opcode == 7'b1110011)                        wd = i.csr_out;
        else                                                    wd = i.alu_out;
        if (i.is_ecall)                           npc = m_mtvec;
        else if (i.is_mret)                       npc = m_mepc;
        else if (i.ben && i.opcode == 7'b1100111) npc = i.alu_out & 32'hFFFF_FFFE;
        else if (i.ben)                           npc = i.alu_out;
        else                                      npc = i.pc + 4;
    endtask

    task automatic model_retire(input instr_t i);
        m_minstret = m_minstret + 1;
        if (i.is_ecall) begin
            m_mepc   = i.pc;
            m_mcause = 11;
        end else if (i.csr_wen) begin
            if (i.csr_waddr == 12'h300) m_mstatus = i.csr_wdata;
            if (i.csr_waddr == 12'h305) m_mtvec   = i.csr_wdata;
            if (i.csr_waddr == 12'h341) m_mepc    = i.csr_wdata;
            if (i.csr_waddr == 12'h342) m_mcause  = i.csr_wdata;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        ben = i.ben; pc = i.pc; csr_out = i.csr_out; opcode = i.opcode;
        gpr_wen = i.gpr_wen; rd = i.rd; csr_wen = i.csr_wen; csr_waddr = i.csr_waddr;
        csr_wdata = i.csr_wdata; is_ecall = i.is_ecall; is_mret = i.is_mret;
        alu_out = i.alu_out; rdata = i.rdata;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        logic [6:0]  ops [6]  = '{7'b0000011, 7'b1101111, 7'b1100111, 7'b1110011, 7'b0010011, 7'b1100011};
        logic [11:0] adrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB02, 12'h7C0};
        i.opcode    = ops[$urandom_range(0, 5)];
        i.ben       = 1'($urandom_range(0, 1));
        i.pc        = $urandom;
        i.csr_out   = $urandom;
        i.gpr_wen   = 1'($urandom_range(0, 1));
        i.rd        = 5'($urandom_range(0, 31));
        i.csr_waddr = adrs[$urandom_range(0, 5)];
        i.csr_wdata = $urandom;
        i.is_ecall  = ($urandom_range(0, 7) == 0);
        i.is_mret   = ($urandom_range(0, 7) == 0);
        i.csr_wen   = i.is_mret ? 1'b0 : 1'($urandom_range(0, 1));
        i.alu_out   = $urandom;
        i.rdata     = $urandom;
        return i;
    endfunction

    // One full IDLE -> WB -> COMMIT(+stall) -> IDLE round trip
    task automatic run_instr(input instr_t i, input int stall, input bit use_tbl,
                             input logic t_we, input logic [31:0] t_wd, input logic [31:0] t_npc);
        logic        e_we;
        logic [31:0] e_wd, e_npc, held_pc;
        model_predict(i, e_we, e_wd, e_npc);
        if (use_tbl) begin
            e_we = t_we; e_wd = t_wd; e_npc = t_npc;
        end
        chk("idle_ready", 32'(ready_out_lsu), 32'd1);
        drive(i);
        valid_in_lsu = 1'b1;
        @(posedge clk); #1;
        valid_in_lsu = 1'b0;
        chk("wb_gpr_we", 32'(gpr_we), 32'(e_we));
        chk("wb_commit", 32'(commit), 32'd1);
        chk("wb_ready", 32'(ready_out_lsu), 32'd0);
        chk("wb_valid", 32'(valid_out_ifu), 32'd0);
        if (e_we) begin
            chk("wb_waddr", 32'(gpr_waddr), 32'(i.rd));
            chk("wb_wdata", gpr_wdata, e_wd);
        end
        csr_raddr = i.csr_waddr; #1;
        chk("wb_csr_old", csr_rdata, model_read(i.csr_waddr));
        model_retire(i);
        @(posedge clk); #1;
        chk("cm_valid", 32'(valid_out_ifu), 32'd1);
        chk("cm_commit", 32'(commit), 32'd0);
        chk("cm_gpr_we", 32'(gpr_we), 32'd0);
        chk("cm_next_pc", next_pc, e_npc);
        #1;
        chk("cm_csr_new", csr_rdata, model_read(i.csr_waddr));
        csr_raddr = 12'hB02; #1;
        chk("minstret", csr_rdata, model_read(12'hB02));
        held_pc = next_pc;
        for (int k = 0; k < stall; k++) begin
            drive(rand_instr());
            valid_in_lsu = 1'b1;
            @(posedge clk); #1;
            chk("stall_pc", next_pc, held_pc);
            chk("stall_ready", 32'(ready_out_lsu), 32'd0);
            chk("stall_valid", 32'(valid_out_ifu), 32'd1);
        end
        valid_in_lsu = 1'b0;
        ready_in_ifu = 1'b1;
        @(posedge clk); #1;
        ready_in_ifu = 1'b0;
        chk("ret_ready", 32'(ready_out_lsu), 32'd1);
        chk("ret_valid", 32'(valid_out_ifu), 32'd0);
        chk("ret_minstret", csr_rdata, model_read(12'hB02));
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [31:0] p, input logic gw,
                                  input logic [4:0] r, input logic [31:0] alu);
        instr_t i;
        i.opcode = op; i.pc = p; i.gpr_wen = gw; i.rd = r; i.alu_out = alu;
        i.ben = 0; i.csr_out = 0; i.csr_wen = 0; i.csr_waddr = 12'h000; i.csr_wdata = 0;
        i.is_ecall = 0; i.is_mret = 0; i.rdata = 0;
        return i;
    endfunction

    vec_t vecs [9];

    initial begin
        logic [11:0] rd_addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB02, 12'hB82, 12'h123};
        instr_t ri;

        vecs[0].ins = mk(7'b0010011, 32'h8000_0000, 1, 5, 32'h1234);
        vecs[0].stall = 5; vecs[0].we = 1; vecs[0].wdata = 32'h1234; vecs[0].npc = 32'h8000_0004;
        vecs[1].ins = mk(7'b0000011, 32'h8000_0004, 1, 0, 32'h0);
        vecs[1].ins.rdata = 32'hDEAD_BEEF;
        vecs[1].stall = 0; vecs[1].we = 0; vecs[1].wdata = 0; vecs[1].npc = 32'h8000_0008;
        vecs[2].ins = mk(7'b1100111, 32'h8000_0010, 1, 1, 32'h8000_0101);
        vecs[2].ins.ben = 1;
        vecs[2].stall = 1; vecs[2].we = 1; vecs[2].wdata = 32'h8000_0014; vecs[2].npc = 32'h8000_0100;
        vecs[3].ins = mk(7'b1110011, 32'h8000_0100, 1, 0, 32'h0);
        vecs[3].ins.csr_wen = 1; vecs[3].ins.csr_waddr = 12'h305; vecs[3].ins.csr_wdata = 32'h8000_0200;
        vecs[3].stall = 0; vecs[3].we = 0; vecs[3].wdata = 0; vecs[3].npc = 32'h8000_0104;
        vecs[4].ins = mk(7'b1110011, 32'h8000_0020, 0, 0, 32'h0);
        vecs[4].ins.is_ecall = 1; vecs[4].ins.csr_wen = 1;
        vecs[4].ins.csr_waddr = 12'h341; vecs[4].ins.csr_wdata = 32'h5555_5555;
        vecs[4].stall = 0; vecs[4].we = 0; vecs[4].wdata = 0; vecs[4].npc = 32'h8000_0200;
        vecs[5].ins = mk(7'b1110011, 32'h8000_0200, 0, 0, 32'h0);
        vecs[5].ins.is_mret = 1; vecs[5].ins.csr_waddr = 12'h341;
        vecs[5].stall = 2; vecs[5].we = 0; vecs[5].wdata = 0; vecs[5].npc = 32'h8000_0020;
        vecs[6].ins = mk(7'b1101111, 32'h8000_0300, 1, 2, 32'h8000_0400);
        vecs[6].ins.ben = 1;
        vecs[6].stall = 0; vecs[6].we = 1; vecs[6].wdata = 32'h8000_0304; vecs[6].npc = 32'h8000_0400;
        vecs[7].ins = mk(7'b1100011, 32'h8000_0400, 0, 0, 32'h8000_0900);
        vecs[7].stall = 0; vecs[7].we = 0; vecs[7].wdata = 0; vecs[7].npc = 32'h8000_0404;
        vecs[8].ins = mk(7'b1110011, 32'h8000_0404, 1, 7, 32'h0);
        vecs[8].ins.csr_out = 32'h0000_CAFE;
        vecs[8].stall = 0; vecs[8].we = 1; vecs[8].wdata = 32'h0000_CAFE; vecs[8].npc = 32'h8000_0408;

        rst = 1'b0; valid_in_lsu = 0; ready_in_ifu = 0; csr_raddr = 12'h300;
        drive(mk(7'b0, 0, 0, 0, 0));
        model_reset();
        #12;
        chk("rst_ready", 32'(ready_out_lsu), 32'd1);
        chk("rst_valid", 32'(valid_out_ifu), 32'd0);
        chk("rst_gpr_we", 32'(gpr_we), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_next_pc", next_pc, RST_PC);
        chk("rst_mstatus", csr_rdata, 32'h0000_1800);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++)
            run_instr(vecs[v].ins, vecs[v].stall, 1'b1, vecs[v].we, vecs[v].wdata, vecs[v].npc);

        chk("mepc_after_trap", m_mepc, 32'h8000_0020);
        for (int a = 0; a < 7; a++) begin
            csr_raddr = rd_addrs[a]; #1;
            chk("csr_read", csr_rdata, model_read(rd_addrs[a]));
        end

        for (int n = 0; n < 40; n++)
            run_instr(rand_instr(), int'($urandom_range(0, 2)), 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of WB of a CSR write to mepc
        ri = mk(7'b1110011, 32'h8000_0500, 1, 3, 32'h0);
        ri.csr_wen = 1; ri.csr_waddr = 12'h341; ri.csr_wdata = 32'h1234_5678; ri.csr_out = 32'h77;
        drive(ri);
        valid_in_lsu = 1'b1;
        @(posedge clk); #1;
        valid_in_lsu = 1'b0;
        chk("prerst_gpr_we", 32'(gpr_we), 32'd1);
        #2 rst = 1'b0; #1;
        chk("arst_gpr_we", 32'(gpr_we), 32'd0);
        chk("arst_commit", 32'(commit), 32'd0);
        chk("arst_ready", 32'(ready_out_lsu), 32'd1);
        chk("arst_next_pc", next_pc, RST_PC);
        model_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_valid", 32'(valid_out_ifu), 32'd0);
        for (int a = 0; a < 7; a++) begin
            csr_raddr = rd_addrs[a]; #1;
            chk("arst_csr", csr_rdata, model_read(rd_addrs[a]));
        end

        run_instr(vecs[0].ins, 0, 1'b1, vecs[0].we, vecs[0].wdata, vecs[0].npc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
